// File: rtl/host_req_axil_sequencer.sv
`default_nettype none
// ============================================================================
// host_req_axil_sequencer: one-at-a-time host register request -> AXI-Lite
// master, with per-state timeout and a sticky error flag.
// Revision: 1.0
// ============================================================================
module host_req_axil_sequencer #(
  parameter int ADDR_BITS      = 16,
  parameter int DATA_BITS      = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 host_req_valid,
  input  logic                 host_req_opcode,
  input  logic [ADDR_BITS-1:0] host_req_addr,
  input  logic [DATA_BITS-1:0] host_req_value,
  output logic                 host_req_deq,
  output logic                 host_resp_valid,
  output logic [DATA_BITS-1:0] host_resp_bits,
  output logic                 m_aw_valid,
  input  logic                 m_aw_ready,
  output logic [ADDR_BITS-1:0] m_aw_addr,
  output logic                 m_w_valid,
  input  logic                 m_w_ready,
  output logic [DATA_BITS-1:0] m_w_data,
  output logic [3:0]           m_w_strb,
  input  logic                 m_b_valid,
  output logic                 m_b_ready,
  input  logic [1:0]           m_b_resp,
  output logic                 m_ar_valid,
  input  logic                 m_ar_ready,
  output logic [ADDR_BITS-1:0] m_ar_addr,
  input  logic                 m_r_valid,
  output logic                 m_r_ready,
  input  logic [DATA_BITS-1:0] m_r_data,
  input  logic [1:0]           m_r_resp,
  output logic                 busy,
  output logic                 err
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [DATA_BITS-1:0] C_TMO_DATA = DATA_BITS'(32'hDEADBEEF);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_REQ  = 3'd1,
    S_WR_RESP = 3'd2,
    S_RD_REQ  = 3'd3,
    S_RD_DATA = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   aw_done_q, aw_done_d;
  logic                   w_done_q, w_done_d;
  logic                   resp_valid_q, resp_valid_d;
  logic [DATA_BITS-1:0]   resp_bits_q, resp_bits_d;
  logic                   err_q, err_d;
  logic [CW-1:0]          tmo_q, tmo_d;
  logic                   timeout, aw_hs, w_hs;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      data_q       <= '0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_bits_q  <= '0;
      err_q        <= 1'b0;
      tmo_q        <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
      resp_valid_q <= resp_valid_d;
      resp_bits_q  <= resp_bits_d;
      err_q        <= err_d;
      tmo_q        <= tmo_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    data_d       = data_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    resp_valid_d = 1'b0;
    resp_bits_d  = resp_bits_q;
    err_d        = err_q;
    host_req_deq = 1'b0;
    m_aw_valid   = 1'b0;
    m_w_valid    = 1'b0;
    m_b_ready    = 1'b0;
    m_ar_valid   = 1'b0;
    m_r_ready    = 1'b0;
    aw_hs        = 1'b0;
    w_hs         = 1'b0;
    // The abort cycle itself masks all handshakes so no transfer races the abort.
    timeout      = (state_q != S_IDLE) && (tmo_q == CW'(TIMEOUT_CYCLES - 1));

    case (state_q)
      S_IDLE: begin
        host_req_deq = host_req_valid;
        if (host_req_valid) begin
          addr_d    = host_req_addr;
          data_d    = host_req_value;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = host_req_opcode ? S_WR_REQ : S_RD_REQ;
        end
      end
      S_WR_REQ: begin
        m_aw_valid = !aw_done_q && !timeout;
        m_w_valid  = !w_done_q && !timeout;
        aw_hs      = m_aw_valid && m_aw_ready;
        w_hs       = m_w_valid && m_w_ready;
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs)  w_done_d  = 1'b1;
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = S_WR_RESP;
      end
      S_WR_RESP: begin
        m_b_ready = !timeout;
        if (m_b_valid && m_b_ready) begin
          state_d = S_IDLE;
          if (m_b_resp != 2'b00) err_d = 1'b1;
        end
      end
      S_RD_REQ: begin
        m_ar_valid = !timeout;
        if (m_ar_valid && m_ar_ready) state_d = S_RD_DATA;
      end
      S_RD_DATA: begin
        m_r_ready = !timeout;
        if (m_r_valid && m_r_ready) begin
          resp_valid_d = 1'b1;
          resp_bits_d  = m_r_data;
          state_d      = S_IDLE;
          if (m_r_resp != 2'b00) err_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (timeout) begin
      state_d = S_IDLE;
      err_d   = 1'b1;
      if (state_q == S_RD_REQ || state_q == S_RD_DATA) begin
        resp_valid_d = 1'b1;
        resp_bits_d  = C_TMO_DATA;
      end
    end

    tmo_d = (state_q == S_IDLE || state_d != state_q) ? '0 : tmo_q + CW'(1);
  end

  assign host_resp_valid = resp_valid_q;
  assign host_resp_bits  = resp_bits_q;
  assign m_aw_addr       = addr_q;
  assign m_ar_addr       = addr_q;
  assign m_w_data        = data_q;
  assign m_w_strb        = 4'hF;
  assign busy            = (state_q != S_IDLE);
  assign err             = err_q;

endmodule
`default_nettype wire

// File: tb/tb_host_req_axil_sequencer.sv
`default_nettype none
// ============================================================================
// tb_host_req_axil_sequencer: directed stimulus with queue-based scoreboard.
// Revision: 1.0
// ============================================================================
module tb_host_req_axil_sequencer;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          clock = 1'b0;
  logic          reset;
  logic          host_req_valid, host_req_opcode;
  logic [AW-1:0] host_req_addr;
  logic [DW-1:0] host_req_value;
  logic          host_req_deq, host_resp_valid;
  logic [DW-1:0] host_resp_bits;
  logic          m_aw_valid, m_aw_ready;
  logic [AW-1:0] m_aw_addr;
  logic          m_w_valid, m_w_ready;
  logic [DW-1:0] m_w_data;
  logic [3:0]    m_w_strb;
  logic          m_b_valid, m_b_ready;
  logic [1:0]    m_b_resp;
  logic          m_ar_valid, m_ar_ready;
  logic [AW-1:0] m_ar_addr;
  logic          m_r_valid, m_r_ready;
  logic [DW-1:0] m_r_data;
  logic [1:0]    m_r_resp;
  logic          busy, err;

  always #5 clock = ~clock;

  host_req_axil_sequencer #(
    .ADDR_BITS(AW), .DATA_BITS(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clock), .reset(reset),
    .host_req_valid(host_req_valid), .host_req_opcode(host_req_opcode),
    .host_req_addr(host_req_addr), .host_req_value(host_req_value),
    .host_req_deq(host_req_deq), .host_resp_valid(host_resp_valid),
    .host_resp_bits(host_resp_bits),
    .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready), .m_aw_addr(m_aw_addr),
    .m_w_valid(m_w_valid), .m_w_ready(m_w_ready), .m_w_data(m_w_data), .m_w_strb(m_w_strb),
    .m_b_valid(m_b_valid), .m_b_ready(m_b_ready), .m_b_resp(m_b_resp),
    .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_addr(m_ar_addr),
    .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_data(m_r_data), .m_r_resp(m_r_resp),
    .busy(busy), .err(err)
  );

  typedef struct packed {
    logic          op;
    logic [AW-1:0] addr;
    logic [DW-1:0] val;
  } req_t;

  req_t          hq[$];
  logic [AW-1:0] exp_aw[$], exp_ar[$];
  logic [DW-1:0] exp_w[$], exp_resp[$];

  int n_checks = 0, n_fail = 0, cyc = 0;
  int n_deq = 0, n_awv = 0, n_wv = 0, n_b = 0, n_resp = 0;
  int cyc_deq = 0, cyc_ar = 0, cyc_rr = 0, cyc_resp = 0;
  logic ar_prev = 1'b0, rr_prev = 1'b0, deq_seen;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  task automatic flag(input string nm, input string what);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got %s, required none", nm, what);
  endtask

  // Host request source: valid/fields follow the queue head, popped one cycle after deq.
  initial begin
    host_req_valid = 1'b0; host_req_opcode = 1'b0; host_req_addr = '0; host_req_value = '0;
    forever begin
      @(negedge clock);
      deq_seen = host_req_valid && host_req_deq;
      @(posedge clock);
      #1;
      if (deq_seen && hq.size() > 0) void'(hq.pop_front());
      if (hq.size() > 0) begin
        host_req_valid  = 1'b1;
        host_req_opcode = hq[0].op;
        host_req_addr   = hq[0].addr;
        host_req_value  = hq[0].val;
      end else begin
        host_req_valid = 1'b0;
      end
    end
  end

  // Monitor: pops expected transfers whenever the DUT completes one.
  always begin
    @(negedge clock);
    if (!reset) begin
      if (host_req_deq && host_req_valid) begin n_deq++; cyc_deq = cyc; end
      if (m_aw_valid) n_awv++;
      if (m_w_valid)  n_wv++;
      if (m_ar_valid && !ar_prev) cyc_ar = cyc;
      if (m_r_ready && !rr_prev)  cyc_rr = cyc;
      if (m_aw_valid && m_aw_ready) begin
        if (exp_aw.size() == 0) flag("aw_unexpected", "AW transfer");
        else check("aw_addr", 64'(m_aw_addr), 64'(exp_aw.pop_front()));
      end
      if (m_w_valid && m_w_ready) begin
        if (exp_w.size() == 0) flag("w_unexpected", "W transfer");
        else check("w_data", 64'(m_w_data), 64'(exp_w.pop_front()));
        check("w_strb", 64'(m_w_strb), 64'hF);
      end
      if (m_b_valid && m_b_ready) n_b++;
      if (m_ar_valid && m_ar_ready) begin
        if (exp_ar.size() == 0) flag("ar_unexpected", "AR transfer");
        else check("ar_addr", 64'(m_ar_addr), 64'(exp_ar.pop_front()));
      end
      if (host_resp_valid) begin
        n_resp++; cyc_resp = cyc;
        if (exp_resp.size() == 0) flag("resp_unexpected", "host_resp pulse");
        else check("resp_bits", 64'(host_resp_bits), 64'(exp_resp.pop_front()));
      end
    end
    ar_prev = m_ar_valid;
    rr_prev = m_r_ready;
  end

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] v);
    req_t r;
    r.op = 1'b1; r.addr = a; r.val = v;
    hq.push_back(r); exp_aw.push_back(a); exp_w.push_back(v);
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] e);
    req_t r;
    r.op = 1'b0; r.addr = a; r.val = '0;
    hq.push_back(r); exp_ar.push_back(a); exp_resp.push_back(e);
  endtask

  task automatic wait_done(input string nm);
    int k;
    k = 0;
    @(negedge clock);
    while ((hq.size() != 0 || busy) && k < 200) begin @(negedge clock); k++; end
    if (hq.size() != 0 || busy) flag(nm, "wait budget expired");
    repeat (2) @(negedge clock);
  endtask

  task automatic wait_aw_valid(input string nm);
    int k;
    k = 0;
    @(negedge clock);
    while (!m_aw_valid && k < 50) begin @(negedge clock); k++; end
    if (!m_aw_valid) flag(nm, "wait budget expired");
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  int s_deq, s_awv, s_wv, s_b, s_resp;
  task automatic snap();
    s_deq = n_deq; s_awv = n_awv; s_wv = n_wv; s_b = n_b; s_resp = n_resp;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    m_aw_ready = 1'b1; m_w_ready = 1'b1; m_ar_ready = 1'b1;
    m_b_valid = 1'b1; m_b_resp = 2'b00;
    m_r_valid = 1'b1; m_r_resp = 2'b00; m_r_data = 32'hCAFEF00D;

    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_busy", 64'(busy), 0);
    check("rst_err", 64'(err), 0);
    check("rst_valids", 64'({m_aw_valid, m_w_valid, m_ar_valid, m_b_ready, m_r_ready}), 0);
    check("rst_resp", 64'({host_resp_valid, host_resp_bits}), 0);
    check("rst_addr_data", 64'({m_aw_addr, m_w_data}), 0);
    @(posedge clock); #1 reset = 1'b0;

    // Simple write, slaves ready
    snap();
    wr(16'h0010, 32'h12345678);
    wait_done("wr1_done");
    check("wr1_deq", 64'(n_deq - s_deq), 1);
    check("wr1_aw_cycles", 64'(n_awv - s_awv), 1);
    check("wr1_w_cycles", 64'(n_wv - s_wv), 1);
    check("wr1_b", 64'(n_b - s_b), 1);
    check("wr1_no_resp", 64'(n_resp - s_resp), 0);
    check("wr1_err", 64'(err), 0);

    // Read latency with ready slaves
    rd(16'h0020, 32'hCAFEF00D);
    wait_done("rd1_done");
    check("rd1_ar_lat", 64'(cyc_ar - cyc_deq), 1);
    check("rd1_rr_lat", 64'(cyc_rr - cyc_deq), 2);
    check("rd1_resp_lat", 64'(cyc_resp - cyc_deq), 3);

    // AW accepted 3 cycles late, W immediately
    snap();
    m_aw_ready = 1'b0;
    wr(16'h0030, 32'hA5A50001);
    wait_aw_valid("split_aw");
    repeat (3) begin @(posedge clock); #1; end
    m_aw_ready = 1'b1;
    wait_done("split_done");
    check("split_aw_cycles", 64'(n_awv - s_awv), 4);
    check("split_w_cycles", 64'(n_wv - s_wv), 1);
    check("split_b", 64'(n_b - s_b), 1);

    // Three queued requests W, R, W
    snap();
    m_r_data = 32'hBEEF0044;
    wr(16'h0040, 32'h00001111);
    rd(16'h0044, 32'hBEEF0044);
    wr(16'h0048, 32'h00002222);
    wait_done("b2b_done");
    check("b2b_deq", 64'(n_deq - s_deq), 3);
    check("b2b_resp", 64'(n_resp - s_resp), 1);
    check("b2b_b", 64'(n_b - s_b), 2);
    check("b2b_err", 64'(err), 0);

    // SLVERR on B sets sticky err
    m_b_resp = 2'b10;
    wr(16'h0050, 32'h00000003);
    wait_done("slverr_done");
    m_b_resp = 2'b00;
    check("slverr_err", 64'(err), 1);

    // Read timeout in RD_DATA
    do_reset();
    m_r_valid = 1'b0;
    rd(16'h0060, 32'hDEADBEEF);
    wait_done("tmo_done");
    check("tmo_resp_lat", 64'(cyc_resp - cyc_deq), 2 + TO);
    check("tmo_err", 64'(err), 1);
    m_r_valid = 1'b1;

    // Reset while in WR_REQ
    m_aw_ready = 1'b0;
    wr(16'h0070, 32'h00000077);
    wait_aw_valid("rst_mid_aw");
    @(posedge clock); #1;
    reset = 1'b1;
    hq.delete(); exp_aw.delete(); exp_w.delete(); exp_ar.delete(); exp_resp.delete();
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("mid_busy", 64'(busy), 0);
    check("mid_err", 64'(err), 0);
    check("mid_valids", 64'({m_aw_valid, m_w_valid, m_ar_valid, m_b_ready, m_r_ready}), 0);
    check("mid_addr", 64'(m_aw_addr), 0);
    m_aw_ready = 1'b1;

    // Recovery read after reset
    m_r_data = 32'h0BADF00D;
    rd(16'h0080, 32'h0BADF00D);
    wait_done("recover_done");
    check("drain_aw", 64'(exp_aw.size()), 0);
    check("drain_w", 64'(exp_w.size()), 0);
    check("drain_ar", 64'(exp_ar.size()), 0);
    check("drain_resp", 64'(exp_resp.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
